// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Memory-access stage and MEM/WB pipeline register of a 5-stage MIPS pipeline.
// Takes the EX/MEM register outputs and drives a request/acknowledge data
// memory port. It registers the write-back result. A request that is not
// acknowledged in its first cycle stalls the upstream stages. If the wait
// runs past TIMEOUT cycles, the access is aborted and a sticky error is
// raised.
//
// Parameters
//   TIMEOUT          maximum wait cycles after the request cycle (1..255)
//
// Ports
//   clk              pipeline clock, rising edge
//   rst              synchronous active-low reset (0 = reset)
//   RegWrite_in      EX/MEM register-file write enable
//   memWrite_in      EX/MEM store request
//   memRead_in       EX/MEM load request
//   memtoReg_in      EX/MEM select memory data for write-back
//   writeDst_in      EX/MEM destination register
//   ALU_in           EX/MEM ALU result (memory address / non-load data)
//   memWriteData_in  EX/MEM store data
//   dmem_req         memory request
//   dmem_we          1 = store, 0 = load
//   dmem_addr        memory address
//   dmem_wdata       store data
//   dmem_rdata       load data, valid when dmem_ack = 1
//   dmem_ack         one-cycle completion pulse from memory
//   stall            freezes PC, IF/ID, ID/EX and EX/MEM
//   MemWB_RegWrite   registered write enable
//   MemWB_Rd         registered destination register
//   regFileWriteData registered write-back data
//   mem_error        sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        memWrite_in,
  input  logic        memRead_in,
  input  logic        memtoReg_in,
  input  logic [4:0]  writeDst_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] memWriteData_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        MemWB_RegWrite,
  output logic [4:0]  MemWB_Rd,
  output logic [31:0] regFileWriteData,
  output logic        mem_error
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // The counter holds the number of WAIT cycles already completed. The abort
  // decision is therefore taken in the WAIT cycle where it equals TIMEOUT-1,
  // and the edge that ends that cycle is the TIMEOUT-th wait edge.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt;

  // Hold registers: they capture the access when the FSM enters WAIT, so the
  // memory port stays stable while upstream inputs are free to change.
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;
  logic        hold_we;
  logic        hold_regwrite;
  logic        hold_memtoreg;
  logic [4:0]  hold_dst;

  logic        access;
  logic        abort;
  logic        sel_regwrite;
  logic        sel_memtoreg;
  logic [4:0]  sel_dst;
  logic [31:0] wb_data;

  // A set memWrite_in wins over memRead_in, so an access with both bits set
  // is a store.
  assign access = memRead_in | memWrite_in;

  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves a signal unassigned would infer a latch.
    state_d      = state_q;
    abort        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = memWrite_in;
    dmem_addr    = ALU_in;
    dmem_wdata   = memWriteData_in;
    sel_regwrite = RegWrite_in;
    sel_memtoreg = memtoReg_in;
    sel_dst      = writeDst_in;

    case (state_q)
      S_IDLE: begin
        dmem_req = access;
        if (access && !dmem_ack) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        dmem_req     = 1'b1;
        dmem_we      = hold_we;
        dmem_addr    = hold_addr;
        dmem_wdata   = hold_wdata;
        sel_regwrite = hold_regwrite;
        sel_memtoreg = hold_memtoreg;
        sel_dst      = hold_dst;
        // When ack and timeout fall in the same cycle, ack wins.
        abort        = !dmem_ack && (wait_cnt == LAST_WAIT);
        if (dmem_ack || abort) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // While in reset, no request leaves the block and upstream is not stalled.
    if (!rst) begin
      state_d  = S_IDLE;
      abort    = 1'b0;
      dmem_req = 1'b0;
    end
  end

  assign stall = dmem_req & ~dmem_ack & ~abort;

  // Only a load that selects memory data takes dmem_rdata. Every other case
  // takes the ALU value (the latched one in WAIT, the live one in IDLE).
  assign wb_data = (dmem_req && !dmem_we && sel_memtoreg) ? dmem_rdata : dmem_addr;

  // NOTE: this block models clocked state, so it uses only non-blocking
  // assignments. Every register then sees the pre-edge values, whatever the
  // statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the hold registers are cleared together with the rest of the
      // state. A reset during WAIT therefore leaves no trace of the discarded
      // access.
      state_q          <= S_IDLE;
      wait_cnt         <= 8'd0;
      hold_addr        <= 32'd0;
      hold_wdata       <= 32'd0;
      hold_we          <= 1'b0;
      hold_regwrite    <= 1'b0;
      hold_memtoreg    <= 1'b0;
      hold_dst         <= 5'd0;
      MemWB_RegWrite   <= 1'b0;
      MemWB_Rd         <= 5'd0;
      regFileWriteData <= 32'd0;
      mem_error        <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && state_d == S_WAIT) begin
        hold_addr     <= ALU_in;
        hold_wdata    <= memWriteData_in;
        hold_we       <= memWrite_in;
        hold_regwrite <= RegWrite_in;
        hold_memtoreg <= memtoReg_in;
        hold_dst      <= writeDst_in;
        wait_cnt      <= 8'd0;
      end else if (state_q == S_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (abort) begin
        mem_error <= 1'b1;
      end

      // A stall edge or an abort edge loads a bubble. Only the write enable
      // drops, so the previous instruction is not written or forwarded again.
      if (stall || abort) begin
        MemWB_RegWrite <= 1'b0;
      end else begin
        MemWB_RegWrite   <= sel_regwrite;
        MemWB_Rd         <= sel_dst;
        regFileWriteData <= wb_data;
      end
    end
  end

endmodule
